twenty_bit_xor_descrambler: RTL and testbench
=============================================

Name: twenty_bit_xor_descrambler

Overview:
- Receive-side counterpart of the 20-bit XOR datapath. Recovers plain words from a scrambled 20-bit word stream.
- Each accepted word is XORed with a 20-bit LFSR keystream word. The LFSR advances once per accepted word.
- Sits between a scrambled-word source and the CPU datapath, with valid/ready handshakes on both sides.
- A single registered output stage decouples the input side from backpressure.

Parameters:
- WIDTH, 20, data and keystream width. Only 20 is supported; the tap positions below are fixed for 20.
- SEED, 20'h5A5A5, LFSR value after reset, and the substitute value when a zero seed is loaded.
- CNT_W, 16, width of the accepted-word counter.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- seed_load  in  1  load seed into the LFSR and flush the output stage.
- seed  in  WIDTH  new LFSR value; a value of 0 is replaced by SEED.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  WIDTH  scrambled word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  WIDTH  descrambled word.
- key  out  WIDTH  current LFSR state, i.e. the keystream for the next accepted word.
- word_cnt  out  CNT_W  number of words accepted since reset or last seed_load.

Behaviour:
- Reset (asynchronous, clears immediately, independent of clk):
  - lfsr = SEED; key = SEED.
  - out_valid = 0; out_data = 0; word_cnt = 0.
  - in_ready = 1 once rst deasserts.
- in_ready is combinational: in_ready = !seed_load && (!out_valid || out_ready).
- Accept condition is accept = in_valid && in_ready. On accept:
  - out_data <= in_data ^ lfsr.
  - out_valid <= 1.
  - lfsr <= {lfsr[18:0], lfsr[19]^lfsr[16]} (polynomial x^20+x^17+1).
  - word_cnt <= word_cnt + 1, wrapping from all-ones to 0 without flag.
- Output drain without refill: if out_valid && out_ready && !accept, then out_valid <= 0 and out_data holds its value.
- Output stall: if out_valid && !out_ready, out_data and out_valid are held stable.
- Latency: 1 cycle from accept to out_valid. Full throughput is 1 word per cycle when out_ready stays high.
- Output-stage state machine: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY->FULL on accept.
  - FULL->FULL on accept together with out_ready.
  - FULL->EMPTY on out_ready without accept.
  - FULL holds on !out_ready.
- seed_load has priority over everything except rst. In that cycle:
  - lfsr <= (seed==0) ? SEED : seed.
  - out_valid <= 0; any pending output word is discarded.
  - word_cnt <= 0.
  - in_ready = 0, so no accept occurs.
- The LFSR never reaches all-zero; the zero-seed substitution guarantees this.
- Reset asserted mid-stream: pending output is lost and the LFSR returns to SEED immediately.

Optional Feature:
- Macro: XOR_DESCR_PARITY_EN.
- When defined:
  - Extra input port in_parity (1 bit) and extra output port parity_err (1 bit).
  - On accept, parity_err <= (^in_data) ^ in_parity, meaning even parity over the scrambled word plus the parity bit.
  - parity_err follows out_valid: it clears when the word drains or is flushed, and resets to 0.
  - Data is still passed through when parity_err = 1.
- When undefined: neither port exists, and behaviour is otherwise identical.

Test Plan:
- Reset: assert rst with no clk edge -> out_valid=0, word_cnt=0, key=20'h5A5A5 immediately; in_ready=1 after release.
- Descramble sequence: seed_load with seed=20'h00001, out_ready=1, then in_data=20'h0005F on two consecutive cycles -> out_data 20'h0005E then 20'h0005D; key goes 20'h00001 -> 20'h00002 -> 20'h00004; word_cnt=2.
- All-ones: seed=20'hFFFFF, in_data=20'hFFFFF -> out_data=20'h00000; next key=20'hFFFFE.
- Backpressure: out_ready=0, two words offered -> first word held in out_data, in_ready=0, second word not accepted and key unchanged; raise out_ready -> second word accepted next cycle.
- Zero seed and flush: with out_valid=1, seed_load with seed=0 -> key=20'h5A5A5, out_valid=0 and word_cnt=0 next cycle, in_ready=0 during the load cycle.
- Parity (XOR_DESCR_PARITY_EN): in_data=20'h00003, in_parity=1 -> parity_err=1; same data with in_parity=0 -> parity_err=0.

Source files
------------

// File: rtl/twenty_bit_xor_descrambler.sv
// twenty_bit_xor_descrambler
//   Receive-side descrambler for the 20-bit XOR datapath. Each accepted
//   scrambled word is XORed with the current LFSR keystream word
//   (x^20 + x^17 + 1). The LFSR then advances once. A single registered
//   output stage with valid/ready absorbs downstream backpressure.
//
//   Optional build macro: XOR_DESCR_PARITY_EN
//     Adds in_parity / parity_err. Even parity is checked over the scrambled
//     word plus its parity bit. The flag travels with the output word.
module twenty_bit_xor_descrambler #(
  parameter int unsigned           WIDTH = 20,
  parameter logic [WIDTH-1:0]      SEED  = 20'h5A5A5,
  parameter int unsigned           CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
`ifdef XOR_DESCR_PARITY_EN
  input  logic             in_parity,
  output logic             parity_err,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] key,
  output logic [CNT_W-1:0] word_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } stage_t;

  stage_t           state;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] lfsr_next;
  logic [WIDTH-1:0] seed_eff;
  logic             accept;

  // Handshake: the stage can take a word when empty or draining this cycle;
  // a seed load blocks acceptance for that cycle.
  always_comb begin
    in_ready = !seed_load && (!out_valid || out_ready);
    accept   = in_valid && in_ready;
  end

  // Keystream step and zero-seed substitution (an all-zero LFSR would lock up).
  always_comb begin
    lfsr_next = {lfsr[18:0], lfsr[19] ^ lfsr[16]};
    seed_eff  = (seed == '0) ? SEED : seed;
  end

  assign key = lfsr;

  // LFSR and accepted-word counter; seed_load restarts both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr     <= SEED;
      word_cnt <= '0;
    end else if (seed_load) begin
      lfsr     <= seed_eff;
      word_cnt <= '0;
    end else if (accept) begin
      lfsr     <= lfsr_next;
      word_cnt <= word_cnt + 1'b1;
    end
  end

  // Output stage FSM (EMPTY/FULL) with registered valid, data and parity flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      out_valid  <= 1'b0;
      out_data   <= '0;
`ifdef XOR_DESCR_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else if (seed_load) begin
      state      <= EMPTY;
      out_valid  <= 1'b0;
`ifdef XOR_DESCR_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state      <= FULL;
            out_valid  <= 1'b1;
            out_data   <= in_data ^ lfsr;
`ifdef XOR_DESCR_PARITY_EN
            parity_err <= (^in_data) ^ in_parity;
`endif
          end
        end
        FULL: begin
          if (accept) begin
            state      <= FULL;
            out_valid  <= 1'b1;
            out_data   <= in_data ^ lfsr;
`ifdef XOR_DESCR_PARITY_EN
            parity_err <= (^in_data) ^ in_parity;
`endif
          end else if (out_ready) begin
            state      <= EMPTY;
            out_valid  <= 1'b0;
`ifdef XOR_DESCR_PARITY_EN
            parity_err <= 1'b0;
`endif
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_twenty_bit_xor_descrambler.sv
// Testbench for twenty_bit_xor_descrambler: directed cases plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_twenty_bit_xor_descrambler;

  localparam logic [19:0] SEED = 20'h5A5A5;

  logic        clk = 1'b0;
  logic        rst;
  logic        seed_load;
  logic [19:0] seed;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_data;
  logic [19:0] key;
  logic [15:0] word_cnt;
`ifdef XOR_DESCR_PARITY_EN
  logic        in_parity;
  logic        parity_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [19:0] m_lfsr;
  logic        m_valid;
  logic [19:0] m_data;
  logic [15:0] m_cnt;
  logic        m_perr;

  always #5 clk = ~clk;

  twenty_bit_xor_descrambler #(
    .WIDTH(20),
    .SEED (SEED),
    .CNT_W(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .seed_load (seed_load),
    .seed      (seed),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef XOR_DESCR_PARITY_EN
    .in_parity (in_parity),
    .parity_err(parity_err),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .key       (key),
    .word_cnt  (word_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [19:0] next_key(input logic [19:0] k);
    logic fb;
    fb = k[19] ^ k[16];
    return ((k * 2) & 20'hFFFFF) | {19'b0, fb};
  endfunction

  task automatic model_reset();
    m_lfsr  = SEED;
    m_valid = 1'b0;
    m_data  = '0;
    m_cnt   = '0;
    m_perr  = 1'b0;
  endtask

  // Called at a negedge: apply inputs, compare, cross the posedge, update model.
  task automatic step(input logic sl, input logic [19:0] sd, input logic iv,
                      input logic [19:0] id, input logic orr);
    logic exp_ready;
    logic acc;
    seed_load = sl;
    seed      = sd;
    in_valid  = iv;
    in_data   = id;
    out_ready = orr;
    #1;
    exp_ready = !sl && (!m_valid || orr);
    check("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
    check("key", {12'b0, key}, {12'b0, m_lfsr});
    check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    if (m_valid) check("out_data", {12'b0, out_data}, {12'b0, m_data});
    check("word_cnt", {16'b0, word_cnt}, {16'b0, m_cnt});
`ifdef XOR_DESCR_PARITY_EN
    check("parity_err", {31'b0, parity_err}, {31'b0, m_perr});
`endif
    @(posedge clk);
    acc = iv && exp_ready;
    if (sl) begin
      m_lfsr  = (sd == 0) ? SEED : sd;
      m_valid = 1'b0;
      m_cnt   = '0;
      m_perr  = 1'b0;
    end else if (acc) begin
      m_data  = id ^ m_lfsr;
      m_valid = 1'b1;
      m_lfsr  = next_key(m_lfsr);
      m_cnt   = m_cnt + 16'd1;
`ifdef XOR_DESCR_PARITY_EN
      m_perr  = (^id) ^ in_parity;
`endif
    end else if (m_valid && orr) begin
      m_valid = 1'b0;
      m_perr  = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    seed_load = 0; seed = '0; in_valid = 0; in_data = '0; out_ready = 1;
`ifdef XOR_DESCR_PARITY_EN
    in_parity = 0;
`endif
    // Asynchronous reset before any clock edge
    rst = 1;
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_word_cnt", {16'b0, word_cnt}, 32'd0);
    check("rst_key", {12'b0, key}, 32'h5A5A5);
    model_reset();
    @(negedge clk);
    rst = 0;
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);

    // Descramble sequence from seed 1
    step(1, 20'h00001, 0, '0, 1);
    check("seq_key0", {12'b0, key}, 32'h00001);
    step(0, '0, 1, 20'h0005F, 1);
    check("seq_out0", {12'b0, out_data}, 32'h0005E);
    check("seq_key1", {12'b0, key}, 32'h00002);
    step(0, '0, 1, 20'h0005F, 1);
    check("seq_out1", {12'b0, out_data}, 32'h0005D);
    check("seq_key2", {12'b0, key}, 32'h00004);
    check("seq_cnt", {16'b0, word_cnt}, 32'd2);
    step(0, '0, 0, '0, 1);

    // All-ones seed and data
    step(1, 20'hFFFFF, 0, '0, 1);
    step(0, '0, 1, 20'hFFFFF, 1);
    check("ones_out", {12'b0, out_data}, 32'h00000);
    check("ones_key", {12'b0, key}, 32'hFFFFE);

    // Backpressure: first word held, second refused until out_ready rises
    step(1, 20'h00001, 0, '0, 0);
    step(0, '0, 1, 20'h00010, 0);
    step(0, '0, 1, 20'h00020, 0);
    check("bp_hold_data", {12'b0, out_data}, 32'h00011);
    check("bp_key_stall", {12'b0, key}, 32'h00002);
    #1;
    check("bp_in_ready", {31'b0, in_ready}, 32'd0);
    step(0, '0, 1, 20'h00020, 1);
    check("bp_second", {12'b0, out_data}, 32'h00022);
    check("bp_cnt", {16'b0, word_cnt}, 32'd2);

    // Zero seed while output is full: flush and substitute SEED
    step(1, 20'h00000, 1, 20'h12345, 0);
    check("zs_key", {12'b0, key}, 32'h5A5A5);
    check("zs_valid", {31'b0, out_valid}, 32'd0);
    check("zs_cnt", {16'b0, word_cnt}, 32'd0);

`ifdef XOR_DESCR_PARITY_EN
    in_parity = 1;
    step(0, '0, 1, 20'h00003, 1);
    check("par_err1", {31'b0, parity_err}, 32'd1);
    in_parity = 0;
    step(0, '0, 1, 20'h00003, 1);
    check("par_err0", {31'b0, parity_err}, 32'd0);
`endif

    // Reset mid-stream
    step(0, '0, 1, 20'hABCDE, 0);
    rst = 1;
    #1;
    check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_key", {12'b0, key}, 32'h5A5A5);
    model_reset();
    @(negedge clk);
    rst = 0;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic        sl;
      logic [19:0] sd;
      sl = ($urandom_range(0, 15) == 0);
      sd = ($urandom_range(0, 3) == 0) ? 20'h0 : 20'($urandom);
`ifdef XOR_DESCR_PARITY_EN
      in_parity = 1'($urandom);
`endif
      step(sl, sd, 1'($urandom_range(0, 3) != 0), 20'($urandom),
           1'($urandom_range(0, 2) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
